// File: rtl/mmio_device_bridge.sv
// mmio_device_bridge: credit-limited pipelined MMIO bridge.
// s0 accept -> s1 device request -> in-order response FIFO.
module mmio_device_bridge #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                clk,
  input  logic                reset,
  output logic                in_req_ready,
  input  logic                in_req_valid,
  input  logic [ADDR_W-1:0]   in_req_bits_addr,
  input  logic [DATA_W-1:0]   in_req_bits_data,
  input  logic [1:0]          in_req_bits_len,
  input  logic                in_req_bits_fcn,
  input  logic [DATA_W/8-1:0] in_req_bits_wstrb,
  input  logic                in_req_bits_is_cached,
  input  logic                in_req_bits_s1_kill,
  input  logic                in_resp_ready,
  output logic                in_resp_valid,
  output logic [DATA_W-1:0]   in_resp_bits_data,
  output logic                dev_req_valid,
  input  logic                dev_req_ready,
  output logic [ADDR_W-1:0]   dev_req_addr,
  output logic [DATA_W-1:0]   dev_req_data,
  output logic [1:0]          dev_req_len,
  output logic                dev_req_fcn,
  output logic [DATA_W/8-1:0] dev_req_wstrb,
  input  logic                dev_resp_valid,
  input  logic [DATA_W-1:0]   dev_resp_data,
  output logic                err_unexpected_resp
);
  localparam int SW = DATA_W / 8;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = CW + 2;

  logic              live;
  logic              s0_valid;
  logic              s0_fresh;
  logic              s1_valid;
  logic [ADDR_W-1:0] s0_addr;
  logic [DATA_W-1:0] s0_data;
  logic [1:0]        s0_len;
  logic              s0_fcn;
  logic [SW-1:0]     s0_wstrb;
  logic [ADDR_W-1:0] s1_addr;
  logic [DATA_W-1:0] s1_data;
  logic [1:0]        s1_len;
  logic              s1_fcn;
  logic [SW-1:0]     s1_wstrb;
  logic [CW-1:0]     inflight;
  logic [CW-1:0]     count;
  logic [PW-1:0]     wptr;
  logic [PW-1:0]     rptr;
  logic [DATA_W-1:0] mem [DEPTH];

  logic          s1_free;
  logic          accept;
  logic          kill;
  logic          move;
  logic          issue;
  logic          push;
  logic          pop;
  logic          full;
  logic [TW-1:0] total;
  logic          unused_cached;

  assign unused_cached = in_req_bits_is_cached;

  // Every request holds one credit from accept until its response pops.
  assign total = TW'(s0_valid) + TW'(s1_valid)
               + TW'(inflight) + TW'(count);

  assign s1_free  = !s1_valid || dev_req_ready;
  assign in_req_ready = live && (!s0_valid || s1_free)
                      && (total < TW'(DEPTH));
  assign accept   = in_req_valid && in_req_ready;
  assign kill     = s0_valid && s0_fresh && in_req_bits_s1_kill;
  assign move     = s0_valid && !kill && s1_free;
  assign issue    = s1_valid && dev_req_ready;
  assign push     = dev_resp_valid && (inflight != '0);
  assign pop      = in_resp_valid && in_resp_ready;
  assign full     = (count == CW'(DEPTH));

  assign dev_req_valid = s1_valid;
  assign dev_req_addr  = s1_addr;
  assign dev_req_data  = s1_data;
  assign dev_req_len   = s1_len;
  assign dev_req_fcn   = s1_fcn;
  assign dev_req_wstrb = s1_wstrb;

  assign in_resp_valid     = (count != '0);
  assign in_resp_bits_data = mem[rptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      live     <= 1'b0;
      s0_valid <= 1'b0;
      s0_fresh <= 1'b0;
      s1_valid <= 1'b0;
    end else begin
      live     <= 1'b1;
      s0_fresh <= accept;
      if (accept)
        s0_valid <= 1'b1;
      else if (move || kill)
        s0_valid <= 1'b0;
      if (move)
        s1_valid <= 1'b1;
      else if (issue)
        s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      s0_addr  <= in_req_bits_addr;
      s0_data  <= in_req_bits_data;
      s0_len   <= in_req_bits_len;
      s0_fcn   <= in_req_bits_fcn;
      s0_wstrb <= in_req_bits_wstrb;
    end
    if (move) begin
      s1_addr  <= s0_addr;
      s1_data  <= s0_data;
      s1_len   <= s0_len;
      s1_fcn   <= s0_fcn;
      s1_wstrb <= s0_wstrb;
    end
    if (push)
      mem[wptr] <= dev_resp_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inflight            <= '0;
      count               <= '0;
      wptr                <= '0;
      rptr                <= '0;
      err_unexpected_resp <= 1'b0;
    end else begin
      unique case ({issue, push})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (push)
        wptr <= wptr + PW'(1);
      if (pop)
        rptr <= rptr + PW'(1);
      if (dev_resp_valid && (inflight == '0))
        err_unexpected_resp <= 1'b1;
    end
  end

  assert property (@(posedge clk) disable iff (!reset)
    !(push && full && !pop));

endmodule

// File: tb/tb_mmio_device_bridge.sv
// tb_mmio_device_bridge: directed scenarios plus randomized traffic
// against a queue-based request/response reference model.
module tb_mmio_device_bridge;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int SW    = DW / 8;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          in_req_ready;
  logic          in_req_valid;
  logic [AW-1:0] in_req_bits_addr;
  logic [DW-1:0] in_req_bits_data;
  logic [1:0]    in_req_bits_len;
  logic          in_req_bits_fcn;
  logic [SW-1:0] in_req_bits_wstrb;
  logic          in_req_bits_is_cached;
  logic          in_req_bits_s1_kill;
  logic          in_resp_ready;
  logic          in_resp_valid;
  logic [DW-1:0] in_resp_bits_data;
  logic          dev_req_valid;
  logic          dev_req_ready;
  logic [AW-1:0] dev_req_addr;
  logic [DW-1:0] dev_req_data;
  logic [1:0]    dev_req_len;
  logic          dev_req_fcn;
  logic [SW-1:0] dev_req_wstrb;
  logic          dev_resp_valid;
  logic [DW-1:0] dev_resp_data;
  logic          err_unexpected_resp;

  mmio_device_bridge #(
    .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_req_ready(in_req_ready),
    .in_req_valid(in_req_valid),
    .in_req_bits_addr(in_req_bits_addr),
    .in_req_bits_data(in_req_bits_data),
    .in_req_bits_len(in_req_bits_len),
    .in_req_bits_fcn(in_req_bits_fcn),
    .in_req_bits_wstrb(in_req_bits_wstrb),
    .in_req_bits_is_cached(in_req_bits_is_cached),
    .in_req_bits_s1_kill(in_req_bits_s1_kill),
    .in_resp_ready(in_resp_ready),
    .in_resp_valid(in_resp_valid),
    .in_resp_bits_data(in_resp_bits_data),
    .dev_req_valid(dev_req_valid),
    .dev_req_ready(dev_req_ready),
    .dev_req_addr(dev_req_addr),
    .dev_req_data(dev_req_data),
    .dev_req_len(dev_req_len),
    .dev_req_fcn(dev_req_fcn),
    .dev_req_wstrb(dev_req_wstrb),
    .dev_resp_valid(dev_resp_valid),
    .dev_resp_data(dev_resp_data),
    .err_unexpected_resp(err_unexpected_resp)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [1:0]    len;
    logic          fcn;
    logic [SW-1:0] wstrb;
  } req_t;

  req_t          req_q[$];
  logic [DW-1:0] rsp_q[$];
  logic [DW-1:0] dpend[$];

  int n_chk = 0;
  int n_fail = 0;
  int n_acc = 0;
  int n_iss = 0;
  int n_pop = 0;
  int lat;

  bit rdy_rand, rdy_val, resp_rand, resp_on, spur;
  bit use_fixed, prev_acc, hold;
  bit acc_s, kill_s, iss_s, pop_s, dresp_s;
  logic [DW-1:0] fixed_data;
  logic [DW-1:0] pop_data;
  req_t held, dreq_s, in_s;

  task automatic check(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] resp_of(input req_t r);
    if (use_fixed) return fixed_data;
    return r.addr ^ {r.data[15:0], r.data[31:16]}
         ^ {29'd0, r.fcn, r.len};
  endfunction

  function automatic req_t cur_dreq();
    return '{dev_req_addr, dev_req_data, dev_req_len,
             dev_req_fcn, dev_req_wstrb};
  endfunction

  task automatic set_req(input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [1:0] l, input logic f,
                         input logic [SW-1:0] w);
    in_req_bits_addr  = a;
    in_req_bits_data  = d;
    in_req_bits_len   = l;
    in_req_bits_fcn   = f;
    in_req_bits_wstrb = w;
  endtask

  // One clock: drive device side, sample handshakes, update the model.
  task automatic cycle();
    dev_req_ready  = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_val;
    dev_resp_valid = 1'b0;
    dev_resp_data  = $urandom;
    if (spur) begin
      dev_resp_valid = 1'b1;
    end else if (resp_on && dpend.size() > 0 &&
                 (!resp_rand || $urandom_range(0, 2) != 0)) begin
      dev_resp_valid = 1'b1;
      dev_resp_data  = dpend[0];
    end
    #1;
    if (hold)
      check("dev_stable", {dev_req_valid, cur_dreq()}, {1'b1, held});
    hold = dev_req_valid && !dev_req_ready;
    held = cur_dreq();
    if (in_req_ready)
      check("credit", rsp_q.size() < DEPTH, 1);
    acc_s    = in_req_valid && in_req_ready;
    kill_s   = in_req_bits_s1_kill;
    in_s     = '{in_req_bits_addr, in_req_bits_data, in_req_bits_len,
                 in_req_bits_fcn, in_req_bits_wstrb};
    iss_s    = dev_req_valid && dev_req_ready;
    dreq_s   = cur_dreq();
    pop_s    = in_resp_valid && in_resp_ready;
    pop_data = in_resp_bits_data;
    dresp_s  = dev_resp_valid;
    @(posedge clk);
    if (pop_s) begin
      n_pop++;
      if (rsp_q.size() == 0) check("resp_extra", 1, 0);
      else check("resp_data", pop_data, rsp_q.pop_front());
    end
    if (dresp_s && dpend.size() > 0)
      void'(dpend.pop_front());
    if (iss_s) begin
      n_iss++;
      if (req_q.size() == 0) check("issue_extra", 1, 0);
      else check("issue_req", dreq_s, req_q.pop_front());
      dpend.push_back(resp_of(dreq_s));
    end
    if (kill_s && prev_acc) begin
      if (req_q.size() > 0) void'(req_q.pop_back());
      if (rsp_q.size() > 0) void'(rsp_q.pop_back());
    end
    if (acc_s) begin
      n_acc++;
      req_q.push_back(in_s);
      rsp_q.push_back(resp_of(in_s));
    end
    prev_acc = acc_s;
    @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    in_req_valid = 0;
    set_req('0, '0, '0, 0, '0);
    in_req_bits_is_cached = 0;
    in_req_bits_s1_kill = 0;
    in_resp_ready = 0;
    dev_req_ready = 0;
    dev_resp_valid = 0;
    dev_resp_data = '0;
    rdy_rand = 0; rdy_val = 1; resp_rand = 0; resp_on = 1;
    spur = 0; use_fixed = 0; prev_acc = 0; hold = 0;
    fixed_data = '0;

    repeat (2) @(negedge clk);
    check("rst_req_ready", in_req_ready, 0);
    check("rst_resp_valid", in_resp_valid, 0);
    check("rst_dev_valid", dev_req_valid, 0);
    check("rst_err", err_unexpected_resp, 0);
    reset = 1;
    cycle();
    check("ready_after_rst", in_req_ready, 1);

    // Single read, minimum latency
    use_fixed = 1;
    fixed_data = 32'hDEAD_BEEF;
    set_req(32'h1000_0000, '0, 2'd2, 1'b0, 4'hf);
    in_req_valid = 1;
    cycle();
    check("t1_accept", acc_s, 1);
    in_req_valid = 0;
    lat = 0;
    while (!in_resp_valid && lat < 20) begin
      cycle();
      lat++;
    end
    check("t1_latency", lat, 3);
    check("t1_data", in_resp_bits_data, 32'hDEAD_BEEF);
    in_resp_ready = 1;
    cycle();
    in_resp_ready = 0;
    check("t1_empty", in_resp_valid, 0);
    check("t1_ready", in_req_ready, 1);
    use_fixed = 0;

    // Back-to-back writes fill the credits
    n_acc = 0;
    for (int i = 0; i < 10; i++) begin
      set_req(32'h2000_0000 + 32'(4 * n_acc), $urandom, 2'd2, 1'b1, 4'hf);
      in_req_valid = 1;
      cycle();
    end
    in_req_valid = 0;
    check("t2_accepted", n_acc, 4);
    check("t2_full_ready", in_req_ready, 0);
    check("t2_resp_valid", in_resp_valid, 1);
    n_pop = 0;
    in_resp_ready = 1;
    for (int i = 0; i < 6; i++) cycle();
    check("t2_pops", n_pop, 4);
    check("t2_ready_again", in_req_ready, 1);

    // Kill of the freshly accepted request
    n_iss = 0; n_pop = 0;
    set_req(32'h3000_0000, 32'h1111_1111, 2'd2, 1'b1, 4'h3);
    in_req_valid = 1;
    cycle();
    set_req(32'h3000_0004, 32'h2222_2222, 2'd1, 1'b0, 4'hc);
    in_req_bits_s1_kill = 1;
    cycle();
    check("t3_b_accept", acc_s, 1);
    in_req_valid = 0;
    in_req_bits_s1_kill = 0;
    repeat (6) cycle();
    check("t3_issues", n_iss, 1);
    check("t3_resps", n_pop, 1);

    // Device stall with a late kill pulse
    n_iss = 0; n_pop = 0;
    rdy_val = 0;
    set_req(32'h4000_0000, 32'hA5A5_0001, 2'd2, 1'b1, 4'hf);
    in_req_valid = 1;
    cycle();
    set_req(32'h4000_0010, 32'hA5A5_0002, 2'd0, 1'b0, 4'h1);
    cycle();
    in_req_valid = 0;
    for (int i = 1; i <= 5; i++) begin
      in_req_bits_s1_kill = (i == 3);
      cycle();
    end
    in_req_bits_s1_kill = 0;
    check("t4_dev_valid", dev_req_valid, 1);
    check("t4_no_issue", n_iss, 0);
    rdy_val = 1;
    repeat (6) cycle();
    check("t4_issues", n_iss, 2);
    check("t4_resps", n_pop, 2);

    // Spurious device response
    check("t5_err_before", err_unexpected_resp, 0);
    spur = 1;
    cycle();
    spur = 0;
    check("t5_err", err_unexpected_resp, 1);
    check("t5_no_resp", in_resp_valid, 0);
    repeat (3) cycle();
    check("t5_err_sticky", err_unexpected_resp, 1);

    // Async reset mid-burst: 2 in flight, 1 buffered
    in_resp_ready = 0;
    resp_on = 0;
    for (int i = 0; i < 3; i++) begin
      set_req(32'h5000_0000 + 32'(i * 4), $urandom, 2'd2, 1'b0, 4'hf);
      in_req_valid = 1;
      cycle();
    end
    in_req_valid = 0;
    repeat (3) cycle();
    resp_on = 1;
    cycle();
    resp_on = 0;
    check("t6_buffered", in_resp_valid, 1);
    #2 reset = 0;
    #1;
    check("t6_rst_resp", in_resp_valid, 0);
    check("t6_rst_dev", dev_req_valid, 0);
    check("t6_rst_ready", in_req_ready, 0);
    check("t6_rst_err", err_unexpected_resp, 0);
    req_q.delete(); rsp_q.delete(); dpend.delete();
    prev_acc = 0; hold = 0;
    @(negedge clk);
    reset = 1;
    resp_on = 1;
    cycle();
    check("t6_ready", in_req_ready, 1);
    check("t6_resp_empty", in_resp_valid, 0);

    // Randomized traffic
    rdy_rand = 1; resp_rand = 1;
    for (int i = 0; i < 3000; i++) begin
      in_req_valid = 1'($urandom_range(0, 1));
      set_req($urandom, $urandom, 2'($urandom), 1'($urandom), 4'($urandom));
      in_req_bits_s1_kill = ($urandom_range(0, 3) == 0);
      in_resp_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    in_req_valid = 0;
    in_req_bits_s1_kill = 0;
    rdy_rand = 0; rdy_val = 1; resp_rand = 0;
    in_resp_ready = 1;
    for (int i = 0; i < 40 && rsp_q.size() > 0; i++) cycle();
    check("drain_rsp", rsp_q.size(), 0);
    check("drain_req", req_q.size(), 0);
    check("drain_err", err_unexpected_resp, 0);
    check("drain_idle", in_resp_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
